// File: rtl/md_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with valid/ready handshakes.
// Define MD_EARLY_OUT_EN to finish in one cycle whenever |a| < |b|.
module md_divider #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_div_op,
    input  logic [WIDTH-1:0] i_operand_a,
    input  logic [WIDTH-1:0] i_operand_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_div_data,
    output logic             o_busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] b_mag_q;
    logic [WIDTH-1:0] fast_value_q;
    logic             fast_q;
    logic             is_rem_q;
    logic             neg_quo_q;
    logic             neg_rem_q;

    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_zero;
    logic             overflow;
    logic             early;
    logic [WIDTH-1:0] fast_value;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] calc_result;

`ifdef MD_EARLY_OUT_EN
    assign early = !div_zero && (a_mag < b_mag);
`else
    assign early = 1'b0;
`endif

    // Request decode on the raw inputs; only meaningful in the accept cycle.
    always_comb begin
        signed_op  = ~i_div_op[0];
        a_neg      = signed_op & i_operand_a[WIDTH-1];
        b_neg      = signed_op & i_operand_b[WIDTH-1];
        a_mag      = a_neg ? -i_operand_a : i_operand_a;
        b_mag      = b_neg ? -i_operand_b : i_operand_b;
        div_zero   = (i_operand_b == '0);
        overflow   = signed_op && (i_operand_a == MIN_NEG) && (i_operand_b == '1);
        fast_value = '0;
        if (div_zero)
            fast_value = i_div_op[1] ? i_operand_a : '1;
        else if (overflow)
            fast_value = i_div_op[1] ? '0 : MIN_NEG;
        else if (i_div_op[1])
            fast_value = i_operand_a;
    end

    // One restoring step; trial bit WIDTH is the borrow that rejects the subtract.
    always_comb begin
        rem_shift   = {rem_q, quo_q[WIDTH-1]};
        trial       = rem_shift - {1'b0, b_mag_q};
        rem_next    = trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_next    = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        calc_result = quo_next;
        if (is_rem_q)
            calc_result = neg_rem_q ? -rem_next : rem_next;
        else if (neg_quo_q)
            calc_result = -quo_next;
    end

    // Fast-path ops still spend one CALC cycle (counter=0) so they report after one edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            counter      <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            b_mag_q      <= '0;
            fast_value_q <= '0;
            fast_q       <= 1'b0;
            is_rem_q     <= 1'b0;
            neg_quo_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
            o_ready      <= 1'b1;
            o_valid      <= 1'b0;
            o_busy       <= 1'b0;
            o_div_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        state        <= CALC;
                        o_ready      <= 1'b0;
                        o_busy       <= 1'b1;
                        rem_q        <= '0;
                        quo_q        <= a_mag;
                        b_mag_q      <= b_mag;
                        is_rem_q     <= i_div_op[1];
                        neg_quo_q    <= a_neg ^ b_neg;
                        neg_rem_q    <= a_neg;
                        fast_value_q <= fast_value;
                        fast_q       <= div_zero | overflow | early;
                        counter      <= (div_zero | overflow | early) ? '0 : CNT_W'(WIDTH - 1);
                    end
                end
                CALC: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    if (counter == '0) begin
                        state      <= DONE;
                        o_valid    <= 1'b1;
                        o_div_data <= fast_q ? fast_value_q : calc_result;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state   <= IDLE;
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        o_busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
